// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter sharing one Booth multiplier core between NREQ requesters
module booth_mult_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        q_in,
  input  logic [NREQ*W-1:0]        m_in,
  output logic [NREQ-1:0]          ack,
  output logic [2*W-1:0]           res_out,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [W-1:0]             mul_q,
  output logic [W-1:0]             mul_m,
  input  logic                     mul_done,
  input  logic [2*W-1:0]           mul_result
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_res_id;
  logic [TW-1:0]   r_timer;
  logic [2*W-1:0]  r_res_out;
  logic            r_err;
  logic [W-1:0]    r_mul_q;
  logic [W-1:0]    r_mul_m;

  logic            w_any;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_done_ok;
  logic            w_tmo;
  logic [NREQ-1:0] w_ack;
  logic            w_start;
  logic            w_busy;

  // A done seen while the timer is still 0 may be left over from the previous operation.
  assign w_done_ok = (r_timer != '0) && mul_done;
  assign w_tmo     = (r_timer == TW'(TIMEOUT_CYC - 1));

  // Round-robin search: first set request after the last served requester, wrapping.
  always_comb begin
    int idx;
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_any && req[idx]) begin
        w_any    = 1'b1;
        w_gnt_id = IDW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    w_start     = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok || w_tmo) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_ack[r_res_id] = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: grant latch, watchdog timer, result capture and round-robin pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= IDW'(NREQ - 1);
      r_res_id  <= '0;
      r_timer   <= '0;
      r_res_out <= '0;
      r_err     <= 1'b0;
      r_mul_q   <= '0;
      r_mul_m   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_res_id <= w_gnt_id;
            r_mul_q  <= q_in[w_gnt_id*W +: W];
            r_mul_m  <= m_in[w_gnt_id*W +: W];
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_done_ok) begin
            r_res_out <= mul_result;
            r_err     <= 1'b0;
          end else if (w_tmo) begin
            r_res_out <= '0;
            r_err     <= 1'b1;
          end
        end
        S_RESP: begin
          r_last <= r_res_id;
        end
        default: ;
      endcase
    end
  end

  assign ack       = w_ack;
  assign res_out   = r_res_out;
  assign res_id    = r_res_id;
  assign err       = r_err;
  assign busy      = w_busy;
  assign mul_start = w_start;
  assign mul_q     = r_mul_q;
  assign mul_m     = r_mul_m;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - directed self-checking bench for booth_mult_arbiter
module tb_booth_mult_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] q_in;
  logic [15:0] m_in;
  logic [3:0]  ack;
  logic [7:0]  res_out;
  logic [1:0]  res_id;
  logic        err;
  logic        busy;
  logic        mul_start;
  logic [3:0]  mul_q;
  logic [3:0]  mul_m;
  logic        mul_done;
  logic [7:0]  mul_result;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] tq [4];
  logic [3:0] tm [4];
  logic [7:0] tr [4];

  booth_mult_arbiter #(.NREQ(4), .W(4), .TIMEOUT_CYC(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .q_in       (q_in),
    .m_in       (m_in),
    .ack        (ack),
    .res_out    (res_out),
    .res_id     (res_id),
    .err        (err),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_q      (mul_q),
    .mul_m      (mul_m),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Waits for the grant, raises done at the d-th negedge after start (d>=2), checks the ack beat.
  task automatic txn(input string tag, input int exp_id, input logic [3:0] eq, input logic [3:0] em,
                     input int d, input logic [7:0] r, input bit drop_req, input bit keep_done);
    int n;
    n = 0;
    while (mul_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_start", tag), mul_start, 1);
    chk($sformatf("%s_grant_id", tag), res_id, exp_id);
    chk($sformatf("%s_mul_q", tag), mul_q, eq);
    chk($sformatf("%s_mul_m", tag), mul_m, em);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      if (i == 1) chk($sformatf("%s_start_width", tag), mul_start, 0);
    end
    mul_done   = 1'b1;
    mul_result = r;
    n = 0;
    while (ack === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_ack_latency", tag), n, 1);
    chk($sformatf("%s_ack", tag), ack, 32'd1 << exp_id);
    chk($sformatf("%s_res_out", tag), res_out, r);
    chk($sformatf("%s_res_id", tag), res_id, exp_id);
    chk($sformatf("%s_err", tag), err, 0);
    if (drop_req) req[exp_id] = 1'b0;
    if (!keep_done) mul_done = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_ack_one_cycle", tag), ack, 0);
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    req        = '0;
    q_in       = '0;
    m_in       = '0;
    mul_done   = 1'b0;
    mul_result = '0;
    tq = '{4'h2, 4'hF, 4'h7, 4'hD};
    tm = '{4'h3, 4'h5, 4'h8, 4'hC};
    tr = '{8'h06, 8'hFB, 8'hC8, 8'h0C};

    // reset state
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_q", mul_q, 0);
    chk("rst_mul_m", mul_m, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // 1: single request, 3 * -6 = -18
    req        = 4'b0001;
    q_in[3:0]  = 4'b0011;
    m_in[3:0]  = 4'b1010;
    txn("t1", 0, 4'h3, 4'hA, 6, 8'hEE, 1, 0);
    chk("t1_idle_after", busy, 0);
    chk("t1_res_hold", res_out, 8'hEE);

    // 2: all four together, two rounds, rr pointer fresh from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < 4; i++) begin
        q_in[i*4 +: 4] = tq[i];
        m_in[i*4 +: 4] = tm[i];
      end
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        txn($sformatf("t2_r%0d_g%0d", rnd, i), i, tq[i], tm[i], 2 + i, tr[i], 1, 0);
      end
    end

    // 3: stale done held from the previous operation must not be accepted
    req       = 4'b0001;
    q_in[3:0] = 4'h1;
    m_in[3:0] = 4'h7;
    txn("t3_prev", 0, 4'h1, 4'h7, 2, 8'h07, 1, 1);
    req       = 4'b0010;
    q_in[7:4] = 4'h2;
    m_in[7:4] = 4'h2;
    n = 0;
    while (mul_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_start", mul_start, 1);
    chk("t3_grant_id", res_id, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t3_stale_ack", ack, 0);
    mul_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t3_still_waiting", ack, 0);
    mul_done   = 1'b1;
    mul_result = 8'h04;
    n = 0;
    while (ack === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ack_latency", n, 1);
    chk("t3_ack", ack, 4'b0010);
    chk("t3_res_out", res_out, 8'h04);
    chk("t3_err", err, 0);
    req      = 4'b0000;
    mul_done = 1'b0;
    @(negedge clk);

    // 4: watchdog timeout, then a normal transaction
    req        = 4'b0100;
    q_in[11:8] = 4'h3;
    m_in[11:8] = 4'h3;
    n = 0;
    while (mul_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start", mul_start, 1);
    chk("t4_grant_id", res_id, 2);
    n = 0;
    while (ack === 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_tmo_latency", n, 65);
    chk("t4_ack", ack, 4'b0100);
    chk("t4_err", err, 1);
    chk("t4_res_out", res_out, 0);
    req[2] = 1'b0;
    @(negedge clk);
    chk("t4_ack_one_cycle", ack, 0);
    req         = 4'b1000;
    q_in[15:12] = 4'h5;
    m_in[15:12] = 4'h5;
    txn("t4_next", 3, 4'h5, 4'h5, 2, 8'h19, 1, 0);

    // 5: asynchronous reset in the middle of WAIT
    req       = 4'b0010;
    q_in[7:4] = 4'h6;
    m_in[7:4] = 4'h3;
    n = 0;
    while (mul_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", mul_start, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_in_wait", busy, 1);
    rst = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_mul_q", mul_q, 0);
    chk("t5_async_mul_m", mul_m, 0);
    chk("t5_async_res_out", res_out, 0);
    chk("t5_async_res_id", res_id, 0);
    chk("t5_async_err", err, 0);
    chk("t5_async_ack", ack, 0);
    @(negedge clk);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_start", mul_start, 0);
    rst = 1'b1;
    txn("t5_after", 1, 4'h6, 4'h3, 3, 8'h12, 1, 0);

    // 6: two requesters held permanently alternate
    req       = 4'b0011;
    q_in[3:0] = 4'h4;
    m_in[3:0] = 4'h4;
    txn("t6_a0", 0, 4'h4, 4'h4, 2, 8'h10, 0, 0);
    txn("t6_a1", 1, 4'h6, 4'h3, 2, 8'h12, 0, 0);
    txn("t6_b0", 0, 4'h4, 4'h4, 3, 8'h10, 0, 0);
    txn("t6_b1", 1, 4'h6, 4'h3, 3, 8'h12, 0, 0);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_start", mul_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
